// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: queues up to two register writes per beat and drains one per cycle into a
// single-write-port register file. Optional same-cycle forwarding is enabled by REGFILE_WB_SCHED_BYPASS_EN.
module regfile_wb_sched #(
  parameter int         DEPTH = 4,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       wb_valid_i,
  output logic                       wb_ready_o,
  input  logic [3:0]                 dstE_i,
  input  logic [63:0]                valE_i,
  input  logic [3:0]                 dstM_i,
  input  logic [63:0]                valM_i,
  output logic                       rf_we_o,
  output logic [3:0]                 rf_waddr_o,
  output logic [63:0]                rf_wdata_o,
  input  logic [3:0]                 srcA_i,
  input  logic [3:0]                 srcB_i,
  output logic                       hazA_o,
  output logic                       hazB_o,
  output logic                       fwdA_o,
  output logic [63:0]                fwdA_data_o,
  output logic                       fwdB_o,
  output logic [63:0]                fwdB_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a beat transfers on a rising edge where wb_valid_i and wb_ready_o are both 1;
  // wb_ready_o depends only on the registered occupancy, never on wb_valid_i.

  logic [3:0]    addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [PW-1:0] head, tail, m_idx;
  logic [CW-1:0] count;
  logic          accept, e_en, m_en, deq;
  logic [1:0]    enq_n;

  assign wb_ready_o = (count <= CW'(DEPTH - 2));
  assign accept     = wb_valid_i & wb_ready_o;
  // E is dropped when M targets the same register: the M value is the architectural result.
  assign e_en       = (dstE_i != RNONE) && (dstE_i != dstM_i);
  assign m_en       = (dstM_i != RNONE);
  assign enq_n      = {1'b0, e_en} + {1'b0, m_en};
  assign m_idx      = tail + PW'(e_en);
  assign deq        = (count != '0);
  assign count_o    = count;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (deq) head <= head + PW'(1);
      if (accept) tail <= tail + PW'(enq_n);
      count <= count + (accept ? CW'(enq_n) : CW'(0)) - CW'(deq);
    end
  end

  // Payload storage carries no reset; occupancy alone defines which slots are live.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && accept) begin
      if (e_en) begin
        addr_q[tail] <= dstE_i;
        data_q[tail] <= valE_i;
      end
      if (m_en) begin
        addr_q[m_idx] <= dstM_i;
        data_q[m_idx] <= valM_i;
      end
    end
  end

  assign rf_we_o    = deq;
  assign rf_waddr_o = deq ? addr_q[head] : 4'd0;
  assign rf_wdata_o = deq ? data_q[head] : 64'd0;

  logic          hit_a, hit_b;
  logic [PW-1:0] idx;
`ifdef REGFILE_WB_SCHED_BYPASS_EN
  logic [63:0]   yng_a, yng_b;
`endif

  // Scan oldest to youngest so the last match seen is the value nearest the tail.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    idx   = '0;
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    yng_a = '0;
    yng_b = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        if ((srcA_i != RNONE) && (addr_q[idx] == srcA_i)) begin
          hit_a = 1'b1;
`ifdef REGFILE_WB_SCHED_BYPASS_EN
          yng_a = data_q[idx];
`endif
        end
        if ((srcB_i != RNONE) && (addr_q[idx] == srcB_i)) begin
          hit_b = 1'b1;
`ifdef REGFILE_WB_SCHED_BYPASS_EN
          yng_b = data_q[idx];
`endif
        end
      end
    end
  end

`ifdef REGFILE_WB_SCHED_BYPASS_EN
  assign hazA_o      = 1'b0;
  assign hazB_o      = 1'b0;
  assign fwdA_o      = hit_a;
  assign fwdB_o      = hit_b;
  assign fwdA_data_o = yng_a;
  assign fwdB_data_o = yng_b;
`else
  assign hazA_o      = hit_a;
  assign hazB_o      = hit_b;
  assign fwdA_o      = 1'b0;
  assign fwdB_o      = 1'b0;
  assign fwdA_data_o = 64'd0;
  assign fwdB_data_o = 64'd0;
`endif

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler between the SEQ/PIPE write-back stage and a single-write-port 16×64 register file. It accepts up to two register writes per instruction (dstE/valE, dstM/valM) through a valid/ready handshake and buffers them in a small FIFO. It drains one write per cycle onto the file. It also reports read-after-write hazards on the two decode read ports against writes still queued.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RNONE, 4'hF, "no register" encoding.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  synchronous active-low reset.
- wb_valid_i  in  1  write-back beat offered.
- wb_ready_o  out  1  beat accepted this cycle if wb_valid_i=1.
- dstE_i  in  4  E destination; RNONE means no write.
- valE_i  in  64  E data.
- dstM_i  in  4  M destination; RNONE means no write.
- valM_i  in  64  M data.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  4  write address.
- rf_wdata_o  out  64  write data.
- srcA_i  in  4  decode read address A.
- srcB_i  in  4  decode read address B.
- hazA_o  out  1  srcA has a queued, unwritten value.
- hazB_o  out  1  srcB has a queued, unwritten value.
- fwdA_o  out  1  fwdA_data_o is valid (bypass build only).
- fwdA_data_o  out  64  forwarded value for srcA.
- fwdB_o  out  1  fwdB_data_o is valid (bypass build only).
- fwdB_data_o  out  64  forwarded value for srcB.
- count_o  out  $clog2(DEPTH)+1  entries occupied.

## Operation

**Enqueue**
- A beat is accepted when wb_valid_i & wb_ready_o.
- wb_ready_o = (DEPTH − count) ≥ 2. This is combinational from the registered count and is independent of wb_valid_i.
- Entries needed per beat:
  - 0 if both destinations are RNONE.
  - 1 if exactly one destination is non-RNONE.
  - 2 if both are non-RNONE and they differ.
  - 1 if dstE_i == dstM_i ≠ RNONE. Only the M write is enqueued (popq %rsp semantics: M wins).
- When two entries are enqueued, E is written to the tail and M to tail+1, so M is written later.

**Dequeue**
- rf_we_o = (count ≠ 0).
- rf_waddr_o and rf_wdata_o come from the head entry.
- The head pops on every cycle where rf_we_o=1. The file never backpressures.

**Pointers and count**
- head and tail wrap modulo DEPTH.
- count_next = count + enq_n − deq (enq_n ∈ {0,1,2}, deq ∈ {0,1}). Simultaneous enqueue and dequeue is legal.

**Hazard**
- hazX_o = 1 when srcX_i ≠ RNONE and any occupied entry (head included) has a matching address.
- The incoming beat in the same cycle is not examined.

**Reset**
- When rst_n_i=0 at an edge: head, tail and count are cleared to 0. Queued writes are discarded, including any mid-drain.
- Entry payloads are not cleared.

## Timing

- Reset values:
  - rf_we_o = 0, count_o = 0, wb_ready_o = 1.
  - hazA_o, hazB_o, fwdA_o, fwdB_o = 0.
  - rf_waddr_o, rf_wdata_o, fwdA_data_o, fwdB_data_o = 0 when the queue is empty.
- Latency: a write accepted at edge N appears on rf_* during cycle N+1 and is committed to the file at edge N+1, provided the queue was empty.
- A second entry from the same beat commits at edge N+2.
- Throughput: one register write per cycle.
- Sustained dual-write beats therefore throttle wb_ready_o.
- Hazard and forward outputs are combinational from srcX_i and the queue state, with no added cycle.

## Configuration

- Macro: `REGFILE_WB_SCHED_BYPASS_EN`.
- **Defined:**
  - A match on srcX sets fwdX_o=1.
  - fwdX_data_o is the youngest matching entry's data (nearest the tail).
  - hazX_o is forced to 0.
- **Undefined:**
  - fwdX_o = 0 and fwdX_data_o = 0 at all times.
  - hazX_o follows the hazard rule above.
  - The forward ports remain present.

## Test plan

- **Reset:** hold rst_n_i=0 for 2 cycles after filling 3 entries. Expect count_o=0, rf_we_o=0, wb_ready_o=1 on the first cycle after release, and no further rf writes.
- **Same destination:** beat dstE=4, valE=0x11, dstM=4, valM=0x22. Expect exactly one rf write to reg 4 with 0x22, and count_o peaks at 1.
- **Order and backpressure (DEPTH=4):** hold valid with dstE=1, dstM=2 every cycle. Expect writes 1, 2, 1, 2, … one per cycle. wb_ready_o drops whenever count_o>2, and count_o never exceeds 4.
- **Simultaneous enqueue/dequeue:** count=2, single-write beat accepted while the head drains. Expect count stays 2 and the new entry commits after the existing two.
- **Hazard (bypass off):** queue reg 7 with 0x5. With srcA=7, srcB=RNONE, expect hazA_o=1 and hazB_o=0. hazA_o drops the cycle after reg 7 commits.
- **Bypass on:** queue reg 3 with 0xA, then reg 3 with 0xB. With srcA=3, expect fwdA_o=1, fwdA_data_o=0xB, hazA_o=0.
